lif_scheduler: RTL
==================

LIF_SCHEDULER -- requirements
Module: lif_scheduler

Interface
REQ-001 Parameter N_NEUR, default 4, number of virtual LIF neurons time-multiplexed on one update datapath.
REQ-002 Parameter THRESH, default 8'd200, spike threshold on the 8-bit membrane state.
REQ-003 Parameter FIFO_DEPTH, default 4, depth of the spike-event queue.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 cfg_we  input  1  write strobe for the per-neuron input-current register.
REQ-007 cfg_addr  input  2  neuron index for cfg_we.
REQ-008 cfg_data  input  8  input current value, unsigned.
REQ-009 start  input  1  request one timestep sweep over all neurons.
REQ-010 busy  output  1  high while the sweep is in the UPDATE or STALL state.
REQ-011 done  output  1  one-cycle pulse when a sweep completes.
REQ-012 state_out  output  8  membrane state committed in the previous cycle.
REQ-013 state_idx  output  2  neuron index of state_out.
REQ-014 state_valid  output  1  high for one cycle per committed neuron update.
REQ-015 spike_vec  output  N_NEUR  spike flags of the last completed sweep.
REQ-016 evt_valid  output  1  spike-event queue non-empty.
REQ-017 evt_id  output  2  neuron index at the queue head.
REQ-018 evt_ready  input  1  consumer accepts the head event when evt_valid=1.

Function
REQ-019 FSM states are IDLE, UPDATE, STALL and DONE.
REQ-020 IDLE -> UPDATE when start=1, with index cleared to 0; start is ignored in every other state.
REQ-021 In UPDATE, per neuron i, one cycle: sum = cur[i] + (st[i] >> 1), 9-bit, saturated to 255.
REQ-022 spike_i = (sum >= THRESH); committed st[i] = 0 if spike_i, else sum.
REQ-023 On commit, state_out is the committed value, state_idx = i, and state_valid = 1 for one cycle.
REQ-024 On commit with spike_i=1, i is pushed to the event queue.
REQ-025 If spike_i=1 and the queue is full with no pop in the same cycle, the FSM SHALL enter/remain in STALL with no commit, no index advance and st[i] unchanged.
REQ-026 STALL -> UPDATE re-evaluation on the first cycle in which space exists or a pop occurs; a simultaneous push and pop on a full queue SHALL be legal.
REQ-027 After the last index commits, go to DONE; DONE SHALL assert done for one cycle, load spike_vec, then return to IDLE.
REQ-028 An unstalled sweep SHALL be exactly N_NEUR UPDATE cycles plus 1 DONE cycle; busy is low in DONE.
REQ-029 cfg_we is accepted in any state; an update of neuron i in the same cycle as a write to i uses the pre-write current.
REQ-030 The event queue is FIFO-ordered; a pop occurs when evt_valid & evt_ready; evt_id is undefined-free and 0 when empty.
REQ-031 No push occurs while a spike is stalled, so no event is ever lost or duplicated.

Reset
REQ-032 rst_n low SHALL immediately force: FSM to IDLE, all st[] and cur[] to 0, queue empty, and busy, done, state_valid, evt_valid, state_out, state_idx, evt_id and spike_vec all to 0.
REQ-033 Reset mid-sweep or mid-stall SHALL abort the sweep with no done pulse; the next start begins at neuron 0.

Verification
REQ-034 Write cur[0]=120, hold evt_ready=1, and run 3 sweeps -> st[0] = 120, 180, then 0 with spike; spike_vec[0]=1 only after sweep 3; evt_id=0 is emitted once.
REQ-035 Write cur[0]=100 and run 10 sweeps -> st[0] takes 100,150,175,187,193,196,198,199,199,199, with no spike.
REQ-036 Write all cur=255 and hold evt_ready=0 -> sweep 1 queues events 0,1,2,3 with busy high for 4 cycles; sweep 2 stalls at neuron 0; a single-cycle evt_ready pulse pops 0, pushes 0 and advances to neuron 1.
REQ-037 Pulse start during busy and write cur[2] in the same cycle neuron 2 updates -> the second start is ignored and neuron 2 uses the old current; the new value applies in the next sweep.
REQ-038 Assert rst_n low during UPDATE at index 2 -> all outputs read 0 asynchronously, no done pulse occurs, and a following start produces state_idx sequence 0,1,2,3.

Source files
------------

// File: rtl/lif_if.sv
// Signal bundle of lif_scheduler: current config, sweep control, committed-state stream
// and the spike-event queue head.
interface lif_if #(parameter int N_NEUR = 4);
  logic              cfg_we;
  logic [1:0]        cfg_addr;
  logic [7:0]        cfg_data;
  logic              start;
  logic              busy;
  logic              done;
  logic [7:0]        state_out;
  logic [1:0]        state_idx;
  logic              state_valid;
  logic [N_NEUR-1:0] spike_vec;
  logic              evt_valid;
  logic [1:0]        evt_id;
  logic              evt_ready;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, evt_ready,
    input  busy, done, state_out, state_idx, state_valid, spike_vec, evt_valid, evt_id
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, evt_ready,
    output busy, done, state_out, state_idx, state_valid, spike_vec, evt_valid, evt_id
  );
endinterface

// File: rtl/lif_scheduler.sv
// Time-multiplexed leaky integrate-and-fire update engine with a spike-event FIFO.
// state  | meaning
// IDLE   | waiting for start
// UPDATE | evaluating and committing neuron idx
// STALL  | neuron idx spiked into a full queue; holding until a slot frees
// DONE   | one-cycle sweep completion, loads spike_vec
module lif_scheduler #(
  parameter int         N_NEUR     = 4,
  parameter logic [7:0] THRESH     = 8'd200,
  parameter int         FIFO_DEPTH = 4
) (
  input logic  clk,
  input logic  rst_n,
  lif_if.slave bus
);
  localparam int         PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int         CW       = $clog2(FIFO_DEPTH + 1);
  localparam logic [1:0] LAST_IDX = 2'(N_NEUR - 1);

  typedef enum logic [1:0] {IDLE, UPDATE, STALL, DONE} state_t;
  state_t state, state_nxt;

  logic [1:0]        idx;
  logic [7:0]        cur [N_NEUR];
  logic [7:0]        st  [N_NEUR];
  logic [N_NEUR-1:0] spk_acc;
  logic [1:0]        fifo [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;

  logic [8:0] sum;
  logic [7:0] sum_sat, commit_val;
  logic       spike, full, nonempty, pop, last;
  logic       active, blocked, commit, push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    sum        = {1'b0, cur[idx]} + {2'b00, st[idx][7:1]};
    sum_sat    = sum[8] ? 8'hff : sum[7:0];
    spike      = (sum_sat >= THRESH);
    commit_val = spike ? 8'h00 : sum_sat;
    full       = (count == CW'(FIFO_DEPTH));
    nonempty   = (count != '0);
    pop        = nonempty & bus.evt_ready;
    last       = (idx == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:          if (bus.start) state_nxt = UPDATE;
      UPDATE, STALL: if (blocked)   state_nxt = STALL;
                     else if (last) state_nxt = DONE;
                     else           state_nxt = UPDATE;
      DONE:          state_nxt = IDLE;
      default:       state_nxt = IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot the stalled spike needs.
  always_comb begin
    active   = (state == UPDATE) || (state == STALL);
    blocked  = active & spike & full & ~pop;
    commit   = active & ~blocked;
    push     = commit & spike;
    bus.busy = active;
    bus.done = (state == DONE);
  end

  assign bus.evt_valid = nonempty;
  assign bus.evt_id    = nonempty ? fifo[rd_ptr] : 2'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          idx <= '0;
    else if (state == IDLE && bus.start) idx <= '0;
    else if (commit && !last)            idx <= idx + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEUR; i++) cur[i] <= '0;
    end else if (bus.cfg_we && (int'(bus.cfg_addr) < N_NEUR)) begin
      cur[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEUR; i++) st[i] <= '0;
      spk_acc         <= '0;
      bus.spike_vec   <= '0;
      bus.state_out   <= '0;
      bus.state_idx   <= '0;
      bus.state_valid <= 1'b0;
    end else begin
      bus.state_valid <= commit;
      if (state == IDLE && bus.start) spk_acc <= '0;
      if (commit) begin
        st[idx]       <= commit_val;
        bus.state_out <= commit_val;
        bus.state_idx <= idx;
        if (spike) spk_acc[idx] <= 1'b1;
      end
      if (state == DONE) bus.spike_vec <= spk_acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= idx;
        wr_ptr       <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule
